tqvp_ptc_multi: RTL and testbench

Multi-channel, parametrised PWM/timer/capture peripheral for the TinyQV peripheral bus. It provides NCH independent channels. Each channel has its own counter, double-buffered period (LRC) and duty (HRC) registers, single-shot mode, polarity control, external-edge counting and input capture. A shared prescaler and a write-1-to-clear interrupt status register serve all channels. Everything runs on one clock: no clock muxing, and every pin input is synchronised and edge-detected.

---
 rtl/tqvp_ptc_multi.sv | 242 ++++++++++++++++++++++++
 tb/tb_tqvp_ptc_multi.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tqvp_ptc_multi.sv
// Multi-channel PWM / timer / input-capture peripheral on the TinyQV peripheral bus.
// NCH channels share one prescaler and one write-1-to-clear interrupt status register.
module tqvp_ptc_multi #(
    parameter int unsigned NCH = 3,
    parameter int unsigned CW  = 16,
    parameter int unsigned PSW = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);

    localparam int unsigned CTW      = 9;
    localparam int unsigned STW      = 11;
    localparam int unsigned B_EN     = 0;
    localparam int unsigned B_ECLK   = 1;
    localparam int unsigned B_NEC    = 2;
    localparam int unsigned B_SINGLE = 3;
    localparam int unsigned B_OE     = 4;
    localparam int unsigned B_INTE   = 5;
    localparam int unsigned B_CAPTE  = 6;
    localparam int unsigned B_POL    = 7;
    localparam int unsigned B_RST    = 8;

    logic [CW-1:0]  cntr_q    [NCH];
    logic [CW-1:0]  cntr_d    [NCH];
    logic [CW-1:0]  hrc_sh_q  [NCH];
    logic [CW-1:0]  hrc_sh_d  [NCH];
    logic [CW-1:0]  lrc_sh_q  [NCH];
    logic [CW-1:0]  lrc_sh_d  [NCH];
    logic [CW-1:0]  hrc_act_q [NCH];
    logic [CW-1:0]  hrc_act_d [NCH];
    logic [CW-1:0]  lrc_act_q [NCH];
    logic [CW-1:0]  lrc_act_d [NCH];
    logic [CTW-1:0] ctrl_q    [NCH];
    logic [CTW-1:0] ctrl_d    [NCH];
    logic [NCH-1:0] pwm_q, pwm_d;

    logic [5:0]     sync1_q, sync2_q, edge_q;
    logic [5:0]     rise, fall;
    logic [PSW-1:0] psc_q, psc_d, prescale_q, prescale_d;
    logic [STW-1:0] status_q, status_d, status_set;

    logic           wr, rd, aligned, glb_sel, psc_tick;
    logic           wr_status, wr_prescale, wr_sync;
    logic [1:0]     reg_sel;
    logic [NCH-1:0] ch_sel, tick, cnt_ev, per_end, wrap, hrc_hit, cap_r, cap_f;
    logic           unused_ok;

    // Bus decode
    assign wr          = data_write_n != 2'b11;
    assign rd          = data_read_n != 2'b11;
    assign aligned     = address[1:0] == 2'b00;
    assign reg_sel     = address[3:2];
    assign glb_sel     = aligned && (address[5:4] == 2'b11);
    assign wr_status   = wr && glb_sel && (reg_sel == 2'd0);
    assign wr_prescale = wr && glb_sel && (reg_sel == 2'd1);
    assign wr_sync     = wr && glb_sel && (reg_sel == 2'd2);
    assign data_ready  = rd;
    assign unused_ok   = ^{data_in, ui_in[7]};

    // Edge detect on the third stage of the pin synchroniser
    assign rise     = sync2_q & ~edge_q;
    assign fall     = ~sync2_q & edge_q;
    assign psc_tick = psc_q >= prescale_q;

    // Per-channel event decode
    always_comb begin
        ch_sel  = '0;
        tick    = '0;
        cnt_ev  = '0;
        per_end = '0;
        wrap    = '0;
        hrc_hit = '0;
        cap_r   = '0;
        cap_f   = '0;
        for (int c = 0; c < NCH; c++) begin
            ch_sel[c]  = aligned && (address[5:4] == 2'(c));
            tick[c]    = ctrl_q[c][B_ECLK] ? (ctrl_q[c][B_NEC] ? fall[c] : rise[c]) : psc_tick;
            cnt_ev[c]  = ctrl_q[c][B_EN] & tick[c] & ~ctrl_q[c][B_RST];
            per_end[c] = cnt_ev[c] & ~ctrl_q[c][B_CAPTE] & (cntr_q[c] == lrc_act_q[c]);
            wrap[c]    = cnt_ev[c] & ctrl_q[c][B_CAPTE] & (cntr_q[c] == {CW{1'b1}});
            hrc_hit[c] = cnt_ev[c] & (cntr_q[c] == hrc_act_q[c] - CW'(1));
            cap_r[c]   = ctrl_q[c][B_CAPTE] & rise[3+c];
            cap_f[c]   = ctrl_q[c][B_CAPTE] & fall[3+c];
        end
    end

    // Per-channel next state; later assignments carry higher priority
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            cntr_d[c]    = cntr_q[c];
            hrc_sh_d[c]  = hrc_sh_q[c];
            lrc_sh_d[c]  = lrc_sh_q[c];
            hrc_act_d[c] = hrc_act_q[c];
            lrc_act_d[c] = lrc_act_q[c];
            ctrl_d[c]    = ctrl_q[c];

            if (per_end[c]) begin
                if (ctrl_q[c][B_SINGLE]) begin
                    ctrl_d[c][B_EN] = 1'b0;
                end else begin
                    cntr_d[c] = '0;
                end
            end else if (cnt_ev[c]) begin
                cntr_d[c] = cntr_q[c] + CW'(1);
            end
            if (ctrl_q[c][B_RST]) begin
                cntr_d[c] = '0;
            end
            if (wr_sync && data_in[c]) begin
                cntr_d[c] = '0;
            end
            if (wr && ch_sel[c] && (reg_sel == 2'd0)) begin
                cntr_d[c] = data_in[CW-1:0];
            end

            if (per_end[c] || !ctrl_q[c][B_EN]) begin
                hrc_act_d[c] = hrc_sh_q[c];
                lrc_act_d[c] = lrc_sh_q[c];
            end
            if (cap_r[c]) begin
                hrc_sh_d[c]  = cntr_q[c];
                hrc_act_d[c] = cntr_q[c];
            end
            if (cap_f[c]) begin
                lrc_sh_d[c]  = cntr_q[c];
                lrc_act_d[c] = cntr_q[c];
            end
            if (wr && ch_sel[c] && (reg_sel == 2'd1)) begin
                hrc_sh_d[c] = data_in[CW-1:0];
            end
            if (wr && ch_sel[c] && (reg_sel == 2'd2)) begin
                lrc_sh_d[c] = data_in[CW-1:0];
            end
            if (wr && ch_sel[c] && (reg_sel == 2'd3)) begin
                ctrl_d[c] = data_in[CTW-1:0];
            end
        end
    end

    // PWM pin value, registered one clock behind the compare
    always_comb begin
        pwm_d = '0;
        for (int c = 0; c < NCH; c++) begin
            pwm_d[c] = ctrl_q[c][B_OE]
                     & ((ctrl_q[c][B_EN] & (cntr_q[c] < hrc_act_q[c])) ^ ctrl_q[c][B_POL]);
        end
    end

    // Shared prescaler and interrupt status (a set beats a same-cycle clear)
    always_comb begin
        psc_d      = (wr_sync || psc_tick) ? '0 : psc_q + PSW'(1);
        prescale_d = wr_prescale ? data_in[PSW-1:0] : prescale_q;
        status_set = '0;
        for (int c = 0; c < NCH; c++) begin
            if (ctrl_q[c][B_INTE]) begin
                status_set[c]   = per_end[c] | wrap[c];
                status_set[4+c] = hrc_hit[c];
                status_set[8+c] = cap_r[c] | cap_f[c];
            end
        end
        status_d = (status_q & ~(wr_status ? data_in[STW-1:0] : {STW{1'b0}})) | status_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                cntr_q[c]    <= '0;
                hrc_sh_q[c]  <= '0;
                lrc_sh_q[c]  <= '0;
                hrc_act_q[c] <= '0;
                lrc_act_q[c] <= '0;
                ctrl_q[c]    <= '0;
            end
            pwm_q      <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            edge_q     <= '0;
            psc_q      <= '0;
            prescale_q <= '0;
            status_q   <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                cntr_q[c]    <= cntr_d[c];
                hrc_sh_q[c]  <= hrc_sh_d[c];
                lrc_sh_q[c]  <= lrc_sh_d[c];
                hrc_act_q[c] <= hrc_act_d[c];
                lrc_act_q[c] <= lrc_act_d[c];
                ctrl_q[c]    <= ctrl_d[c];
            end
            pwm_q      <= pwm_d;
            sync1_q    <= ui_in[5:0];
            sync2_q    <= sync1_q;
            edge_q     <= sync2_q;
            psc_q      <= psc_d;
            prescale_q <= prescale_d;
            status_q   <= status_d;
        end
    end

    // Combinational read-back; reads return the shadow compare registers
    always_comb begin
        data_out = '0;
        if (rd && glb_sel) begin
            case (reg_sel)
                2'd0:    data_out = 32'(status_q);
                2'd1:    data_out = 32'(prescale_q);
                default: data_out = '0;
            endcase
        end else if (rd) begin
            for (int c = 0; c < NCH; c++) begin
                if (ch_sel[c]) begin
                    case (reg_sel)
                        2'd0:    data_out = 32'(cntr_q[c]);
                        2'd1:    data_out = 32'(hrc_sh_q[c]);
                        2'd2:    data_out = 32'(lrc_sh_q[c]);
                        default: data_out = 32'(ctrl_q[c]);
                    endcase
                end
            end
        end
    end

    always_comb begin
        uo_out = '0;
        for (int c = 0; c < NCH; c++) begin
            uo_out[1+c] = pwm_q[c];
        end
    end

    assign user_interrupt = |status_q;

endmodule

// File: tb/tb_tqvp_ptc_multi.sv
// Directed and randomised bench for tqvp_ptc_multi; expected pin/register values
// come from arithmetic on the programmed period, duty, prescale and pin timing.
`timescale 1ns/1ps
module tb_tqvp_ptc_multi;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  ui_in = 8'h00;
    logic [7:0]  uo_out;
    logic [5:0]  address = 6'h00;
    logic [31:0] data_in = 32'h0;
    logic [1:0]  data_write_n = 2'b11;
    logic [1:0]  data_read_n = 2'b11;
    logic [31:0] data_out;
    logic        data_ready;
    logic        user_interrupt;

    int tests = 0;
    int fails = 0;

    tqvp_ptc_multi dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ui_in          (ui_in),
        .uo_out         (uo_out),
        .address        (address),
        .data_in        (data_in),
        .data_write_n   (data_write_n),
        .data_read_n    (data_read_n),
        .data_out       (data_out),
        .data_ready     (data_ready),
        .user_interrupt (user_interrupt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Call from the low clock phase; the write lands on the next rising edge
    task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
        address      = a;
        data_in      = d;
        data_write_n = 2'b10;
        @(negedge clk);
        data_write_n = 2'b11;
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
        address     = a;
        data_read_n = 2'b10;
        #1;
        d           = data_out;
        data_read_n = 2'b11;
    endtask

    task automatic read_chk(input string tag, input logic [5:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        chk(tag, d, exp);
    endtask

    // Program a channel from a quiet state and restart it with SYNC (edge "0")
    task automatic setup(input int ch, input int l, input int h, input int p, input int ctrl);
        logic [5:0] base;
        base = 6'(ch * 16);
        bus_write(base + 6'hC, 32'h0);
        bus_write(6'h34, 32'(p));
        bus_write(base, 32'h0);
        bus_write(base + 6'h8, 32'(l));
        bus_write(base + 6'h4, 32'(h));
        bus_write(base + 6'hC, 32'(ctrl));
        bus_write(6'h38, 32'(1 << ch));
    endtask

    // Pin after edge n reflects the counter after edge n-1
    function automatic logic exp_pin(input int n, input int l, input int h, input int p, input int pol);
        int cnt;
        cnt = ((n - 1) / (p + 1)) % (l + 1);
        return logic'((cnt < h) ? 1 : 0) ^ logic'(pol);
    endfunction

    task automatic check_pwm(input int ch, input int l, input int h, input int p, input int pol);
        int ncyc;
        ncyc = 2 * (l + 1) * (p + 1) + 2;
        setup(ch, l, h, p, 32'h11 | (pol << 7));
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            chk($sformatf("pwm ch%0d L%0d H%0d P%0d pol%0d n%0d", ch, l, h, p, pol, n),
                32'(uo_out[1+ch]), 32'(exp_pin(n, l, h, p, pol)));
        end
        bus_write(6'(ch * 16) + 6'hC, 32'h0);
    endtask

    initial begin
        logic [31:0] hv, lv;
        int k, nec, exp_cnt;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst uo_out", 32'(uo_out), 32'h0);
        chk("rst irq", 32'(user_interrupt), 32'h0);
        chk("rst data_out idle", data_out, 32'h0);
        chk("rst data_ready idle", 32'(data_ready), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 4; r++) begin
                read_chk($sformatf("rst reg ch%0d r%0d", c, r), 6'(c * 16 + r * 4), 32'h0);
                @(negedge clk);
            end
        end
        read_chk("rst status", 6'h30, 32'h0);
        @(negedge clk);
        address = 6'h00;
        data_read_n = 2'b10;
        #1;
        chk("data_ready on read", 32'(data_ready), 32'h1);
        data_read_n = 2'b11;
        @(negedge clk);

        // Basic PWM on channel 0
        check_pwm(0, 9, 3, 0, 0);
        chk("unused pins zero", 32'(uo_out & 8'hF1), 32'h0);

        // Duty edge cases
        check_pwm(1, 9, 0, 0, 1);
        check_pwm(2, 9, 20, 0, 0);

        // Randomised PWM configurations
        for (int i = 0; i < 8; i++) begin
            check_pwm(int'($urandom_range(0, 2)), int'($urandom_range(1, 12)),
                      int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 1)));
        end
        bus_write(6'h34, 32'h2);
        read_chk("prescale readback", 6'h34, 32'h2);
        @(negedge clk);

        // Shadow update: new duty takes effect at the 9->0 boundary
        setup(0, 9, 3, 0, 32'h11);
        for (int n = 1; n <= 2; n++) begin
            @(negedge clk);
            chk($sformatf("shadow n%0d", n), 32'(uo_out[1]), 32'(exp_pin(n, 9, 3, 0, 0)));
        end
        bus_write(6'h04, 32'd7);
        chk("shadow n3", 32'(uo_out[1]), 32'(exp_pin(3, 9, 3, 0, 0)));
        for (int n = 4; n <= 30; n++) begin
            @(negedge clk);
            chk($sformatf("shadow n%0d", n), 32'(uo_out[1]),
                32'(exp_pin(n, 9, (n - 1 >= 10) ? 7 : 3, 0, 0)));
        end
        read_chk("shadow hrc readback", 6'h04, 32'd7);
        @(negedge clk);
        bus_write(6'h0C, 32'h0);

        // Single shot with interrupt
        setup(0, 5, 3, 0, 32'h29);
        repeat (20) @(negedge clk);
        read_chk("single cntr", 6'h00, 32'd5);
        read_chk("single ctrl", 6'h0C, 32'h28);
        read_chk("single status", 6'h30, 32'h11);
        chk("single irq", 32'(user_interrupt), 32'h1);
        @(negedge clk);
        bus_write(6'h30, 32'h1);
        read_chk("w1c status", 6'h30, 32'h10);
        chk("w1c irq still", 32'(user_interrupt), 32'h1);
        @(negedge clk);
        bus_write(6'h30, 32'h10);
        chk("w1c irq clear", 32'(user_interrupt), 32'h0);
        bus_write(6'h0C, 32'h0);

        // External edge counting on channel 2
        for (int i = 0; i < 2; i++) begin
            k   = int'($urandom_range(1, 8));
            nec = int'($urandom_range(0, 1));
            setup(2, 100, 0, 0, 32'h3 | (nec << 2));
            for (int j = 0; j < k; j++) begin
                ui_in[2] = 1'b1;
                repeat (3) @(negedge clk);
                ui_in[2] = 1'b0;
                repeat (3) @(negedge clk);
            end
            ui_in[2] = 1'b1;
            repeat (6) @(negedge clk);
            exp_cnt = (nec != 0) ? k : k + 1;
            read_chk($sformatf("eclk k%0d nec%0d", k, nec), 6'h20, 32'(exp_cnt));
            @(negedge clk);
            bus_write(6'h2C, 32'h0);
            ui_in[2] = 1'b0;
            repeat (5) @(negedge clk);
        end

        // Capture on channel 1: rising edge at counter 100, 50 clk pulse
        setup(1, 0, 0, 0, 32'h61);
        repeat (100) @(negedge clk);
        ui_in[4] = 1'b1;
        repeat (50) @(negedge clk);
        ui_in[4] = 1'b0;
        repeat (10) @(negedge clk);
        bus_read(6'h14, hv);
        bus_read(6'h18, lv);
        chk("capture hrc", hv, 32'd102);
        chk("capture lrc", lv, 32'd152);
        chk("capture width", lv - hv, 32'd50);
        read_chk("capture status", 6'h30, 32'h200);
        @(negedge clk);
        bus_write(6'h1C, 32'h0);
        bus_write(6'h30, 32'h7FF);

        // SYNC clears all counters in one cycle; CNTR write beats count event
        setup(0, 1000, 0, 0, 32'h1);
        setup(1, 1000, 0, 0, 32'h1);
        setup(2, 1000, 0, 0, 32'h1);
        repeat (5) @(negedge clk);
        bus_write(6'h38, 32'h7);
        read_chk("sync cntr0", 6'h00, 32'h0);
        read_chk("sync cntr1", 6'h10, 32'h0);
        read_chk("sync cntr2", 6'h20, 32'h0);
        repeat (4) @(negedge clk);
        read_chk("after sync cntr1", 6'h10, 32'd4);
        @(negedge clk);
        bus_write(6'h00, 32'h1234);
        read_chk("cntr write priority", 6'h00, 32'h1234);
        @(negedge clk);
        bus_write(6'h0C, 32'h101);
        repeat (5) @(negedge clk);
        read_chk("cntrrst holds", 6'h00, 32'h0);
        @(negedge clk);
        bus_write(6'h0C, 32'h0);
        bus_write(6'h1C, 32'h0);
        bus_write(6'h2C, 32'h0);

        // Unmapped addresses
        bus_write(6'h3C, 32'hFFFF_FFFF);
        read_chk("unmapped 0x3c", 6'h3C, 32'h0);
        read_chk("sync reads 0", 6'h38, 32'h0);
        @(negedge clk);

        // Asynchronous reset mid-operation
        setup(0, 9, 0, 0, 32'h91);
        repeat (3) @(negedge clk);
        chk("pol pin high", 32'(uo_out[1]), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst pin", 32'(uo_out), 32'h0);
        read_chk("async rst cntr", 6'h00, 32'h0);
        read_chk("async rst ctrl", 6'h0C, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
